// File: rtl/rf_multiport_pkg.sv
// Shared pipeline types: writeback bundle and register-file init states.
package pipeline;

    localparam int XLEN      = 32;
    localparam int RF_ADDR_W = 5;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] rd_addr;
        logic [XLEN-1:0]      data;
    } writeback_signals;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_t;

endpackage

// File: rtl/rf_multiport_scoreboard.sv
// Pending-write scoreboard: issue sets a bit, writeback clears it, set wins.
module rf_scoreboard #(
    parameter int NREGS  = 32,
    parameter int NWRITE = 1,
    parameter int AW     = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   set_valid_i,
    input  logic [AW-1:0]          set_addr_i,
    input  logic [NWRITE-1:0]      clr_valid_i,
    input  logic [NWRITE*AW-1:0]   clr_addr_i,
    output logic [NREGS-1:0]       busy_o
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Callers pre-qualify addresses, so every enabled index is in range.
    always_comb begin
        busy_d = busy_q;
        for (int w = 0; w < NWRITE; w++) begin
            if (clr_valid_i[w]) begin
                busy_d[clr_addr_i[w*AW +: AW]] = 1'b0;
            end
        end
        if (set_valid_i) begin
            busy_d[set_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/rf_multiport.sv
// Multi-port register file with self-clearing init, write bypass and scoreboard.
module rf_multiport
    import pipeline::*;
#(
    parameter int NREAD    = 2,
    parameter int NWRITE   = 1,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NREAD*AW-1:0]          rd_addr,
    output logic [NREAD*XLEN-1:0]        rd_data,
    output logic [NREAD-1:0]             rd_busy,
    input  logic [NWRITE-1:0]            wb_valid,
    input  writeback_signals [NWRITE-1:0] wb_in,
    input  logic                         issue_valid,
    input  logic [AW-1:0]                issue_rd,
    output logic [NREGS-1:0]             busy,
    output logic                         ready
);

    localparam logic [AW:0]   NREGS_L  = (AW+1)'(NREGS);
    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    rf_state_t       state_q, state_d;
    logic [AW-1:0]   clr_idx_q, clr_idx_d;
    logic            ready_q;
    logic [XLEN-1:0] regs_q [NREGS];

    logic [NWRITE-1:0]    wr_en;
    logic [NWRITE*AW-1:0] wr_addr;
    logic                 issue_en;
    logic [AW-1:0]        ra;
    logic                 hit;
    logic [XLEN-1:0]      rval;

    // Address is storable/readable: in range and not the hardwired zero register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < NREGS_L) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            CLEAR: begin
                if (clr_idx_q == LAST_IDX) begin
                    state_d   = RUN;
                    clr_idx_d = '0;
                end else begin
                    clr_idx_d = clr_idx_q + 1'b1;
                end
            end
            RUN: ;
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            ready_q   <= (state_d == RUN);
        end
    end

    always_comb begin
        wr_en   = '0;
        wr_addr = '0;
        for (int w = 0; w < NWRITE; w++) begin
            wr_addr[w*AW +: AW] = wb_in[w].rd_addr[AW-1:0];
            wr_en[w] = (state_q == RUN) && wb_valid[w] && addr_ok(wb_in[w].rd_addr[AW-1:0]);
        end
        issue_en = (state_q == RUN) && issue_valid && addr_ok(issue_rd);
    end

    // Later ports overwrite earlier ones, giving highest-index priority.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == CLEAR) begin
                regs_q[clr_idx_q] <= '0;
            end else begin
                for (int w = 0; w < NWRITE; w++) begin
                    if (wr_en[w]) begin
                        regs_q[wr_addr[w*AW +: AW]] <= wb_in[w].data;
                    end
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        hit     = 1'b0;
        rval    = '0;
        for (int i = 0; i < NREAD; i++) begin
            ra   = rd_addr[i*AW +: AW];
            hit  = 1'b0;
            rval = '0;
            if ((state_q == RUN) && addr_ok(ra)) begin
                rval = regs_q[ra];
                for (int w = 0; w < NWRITE; w++) begin
                    if (wr_en[w] && (wr_addr[w*AW +: AW] == ra)) begin
                        hit  = 1'b1;
                        rval = wb_in[w].data;
                    end
                end
                rd_busy[i] = busy[ra] && !hit;
            end
            rd_data[i*XLEN +: XLEN] = rval;
        end
    end

    rf_scoreboard #(
        .NREGS  (NREGS),
        .NWRITE (NWRITE),
        .AW     (AW)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .set_valid_i (issue_en),
        .set_addr_i  (issue_rd),
        .clr_valid_i (wr_en),
        .clr_addr_i  (wr_addr),
        .busy_o      (busy)
    );

    assign ready = ready_q;

endmodule

// File: tb/tb_rf_multiport.sv
// Directed bench for rf_multiport with two read and two write ports.
module tb_rf_multiport;
    import pipeline::*;

    localparam int NREAD  = 2;
    localparam int NWRITE = 2;
    localparam int NREGS  = 32;
    localparam int AW     = 5;

    logic                          clk = 1'b0;
    logic                          rst;
    logic [NREAD*AW-1:0]           rd_addr;
    logic [NREAD*XLEN-1:0]         rd_data;
    logic [NREAD-1:0]              rd_busy;
    logic [NWRITE-1:0]             wb_valid;
    writeback_signals [NWRITE-1:0] wb_in;
    logic                          issue_valid;
    logic [AW-1:0]                 issue_rd;
    logic [NREGS-1:0]              busy;
    logic                          ready;

    int checks = 0;
    int errors = 0;

    rf_multiport #(
        .NREAD    (NREAD),
        .NWRITE   (NWRITE),
        .NREGS    (NREGS),
        .ZERO_REG (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .wb_valid    (wb_valid),
        .wb_in       (wb_in),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .busy        (busy),
        .ready       (ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_valid    = '0;
        wb_in       = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic clear_phase(input string tag);
        for (int i = 0; i < NREGS; i++) begin
            set_rd(AW'(i), AW'(NREGS - 1 - i));
            if (i == 30) begin
                wb_valid       = 2'b01;
                wb_in[0].rd_addr = 5'd5;
                wb_in[0].data    = 32'hFFFF_FFFF;
                issue_valid    = 1'b1;
                issue_rd       = 5'd6;
            end
            #1;
            chk({tag, "_ready_low"}, {31'd0, ready}, 32'd0);
            chk({tag, "_rd0_zero"}, rd_data[31:0], 32'd0);
            chk({tag, "_rd1_zero"}, rd_data[63:32], 32'd0);
            chk({tag, "_rdbusy_zero"}, {30'd0, rd_busy}, 32'd0);
            tick();
            idle_inputs();
        end
        #1;
        chk({tag, "_ready_high"}, {31'd0, ready}, 32'd1);
        chk({tag, "_busy_zero"}, busy, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        set_rd('0, '0);
        tick();
        rst = 1'b0;
        #1;
        chk("reset_ready", {31'd0, ready}, 32'd0);
        chk("reset_busy", busy, 32'd0);
        clear_phase("init");

        // Every register reads zero after init, including the write ignored during CLEAR.
        for (int i = 0; i < NREGS / 2; i++) begin
            set_rd(AW'(2 * i), AW'(2 * i + 1));
            #1;
            chk("run_rd0_zero", rd_data[31:0], 32'd0);
            chk("run_rd1_zero", rd_data[63:32], 32'd0);
        end

        // Same-cycle bypass to port 1, then storage read.
        set_rd(5'd4, 5'd5);
        wb_valid = 2'b01;
        wb_in[0].rd_addr = 5'd5;
        wb_in[0].data    = 32'hDEAD_BEEF;
        #1;
        chk("bypass_rd1", rd_data[63:32], 32'hDEAD_BEEF);
        chk("bypass_rd0_other", rd_data[31:0], 32'd0);
        tick();
        idle_inputs();
        #1;
        chk("storage_rd1", rd_data[63:32], 32'hDEAD_BEEF);
        chk("write_nonbusy", busy, 32'd0);

        // Two ports to one register: port 1 wins.
        set_rd(5'd7, 5'd0);
        wb_valid = 2'b11;
        wb_in[0].rd_addr = 5'd7;
        wb_in[0].data    = 32'h11;
        wb_in[1].rd_addr = 5'd7;
        wb_in[1].data    = 32'h22;
        #1;
        chk("dual_bypass", rd_data[31:0], 32'h22);
        tick();
        idle_inputs();
        #1;
        chk("dual_storage", rd_data[31:0], 32'h22);

        // Register 0 stays zero.
        set_rd(5'd0, 5'd7);
        wb_valid = 2'b01;
        wb_in[0].rd_addr = 5'd0;
        wb_in[0].data    = 32'h1234;
        #1;
        chk("r0_bypass", rd_data[31:0], 32'd0);
        tick();
        idle_inputs();
        #1;
        chk("r0_storage", rd_data[31:0], 32'd0);

        // Issue to register 0 is dropped.
        issue_valid = 1'b1;
        issue_rd    = 5'd0;
        tick();
        idle_inputs();
        #1;
        chk("r0_issue", busy, 32'd0);

        // Scoreboard set, then writeback with same-cycle read.
        issue_valid = 1'b1;
        issue_rd    = 5'd3;
        tick();
        idle_inputs();
        set_rd(5'd3, 5'd3);
        #1;
        chk("issue_busy3", busy, 32'h0000_0008);
        chk("rdbusy_pending", {30'd0, rd_busy}, 32'd3);
        wb_valid = 2'b01;
        wb_in[0].rd_addr = 5'd3;
        wb_in[0].data    = 32'hCAFE_0003;
        #1;
        chk("rdbusy_bypass", {30'd0, rd_busy}, 32'd0);
        chk("rd_bypass3", rd_data[31:0], 32'hCAFE_0003);
        tick();
        idle_inputs();
        #1;
        chk("busy3_cleared", busy, 32'd0);

        // Issue and write to reg9 together: set wins.
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        wb_valid = 2'b10;
        wb_in[1].rd_addr = 5'd9;
        wb_in[1].data    = 32'h99;
        tick();
        idle_inputs();
        set_rd(5'd9, 5'd9);
        #1;
        chk("set_wins", busy, 32'h0000_0200);
        chk("reg9_data", rd_data[31:0], 32'h99);
        wb_valid = 2'b01;
        wb_in[0].rd_addr = 5'd9;
        wb_in[0].data    = 32'h9A;
        tick();
        idle_inputs();
        #1;
        chk("busy9_cleared", busy, 32'd0);

        // Preload reg20 and mark reg21 busy, then reset mid-clear.
        wb_valid = 2'b01;
        wb_in[0].rd_addr = 5'd20;
        wb_in[0].data    = 32'hA5A5_A5A5;
        issue_valid = 1'b1;
        issue_rd    = 5'd21;
        tick();
        idle_inputs();
        set_rd(5'd20, 5'd21);
        #1;
        chk("preload_r20", rd_data[31:0], 32'hA5A5_A5A5);
        chk("preload_busy21", busy, 32'h0020_0000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b0;
        #1;
        chk("rerst_ready", {31'd0, ready}, 32'd0);
        chk("rerst_busy", busy, 32'd0);
        clear_phase("restart");
        set_rd(5'd20, 5'd21);
        #1;
        chk("restart_r20", rd_data[31:0], 32'd0);
        chk("restart_r21", rd_data[63:32], 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
